// File: rtl/conv_sequencer_pkg.sv
// Shared sizing constants and FSM encoding for the 3x3 convolution sequencer.
package conv_pkg;
    localparam int N       = 8;
    localparam int M_AW    = 10;
    localparam int F_AW    = 3;
    localparam int IMG     = 28;
    localparam int FIL     = 3;
    localparam int OUT_DIM = IMG - FIL + 1;
    localparam int ACC_W   = 2 * N + 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        WRITE,
        FIN
    } state_t;
endpackage

// File: rtl/conv_sequencer_if.sv
// Control and memory-side bus of the convolution sequencer; the master modport is the sequencer.
interface conv_sequencer_if #(
    parameter int N    = conv_pkg::N,
    parameter int M_AW = conv_pkg::M_AW,
    parameter int F_AW = conv_pkg::F_AW
) ();
    logic            start;
    logic [M_AW-1:0] src_base;
    logic [F_AW-1:0] fil_sel;
    logic [M_AW-1:0] dst_base;
    logic [M_AW-1:0] src1;
    logic [F_AW-1:0] src2;
    logic [10*N-1:0] I_out;
    logic [9*N-1:0]  F_out;
    logic            wren;
    logic [M_AW-1:0] dest;
    logic [N-1:0]    D;
    logic            busy;
    logic            done;

    modport master (
        input  start, src_base, fil_sel, dst_base, I_out, F_out,
        output src1, src2, wren, dest, D, busy, done
    );

    modport slave (
        output start, src_base, fil_sel, dst_base, I_out, F_out,
        input  src1, src2, wren, dest, D, busy, done
    );
endinterface

// File: rtl/conv_sequencer_mac9.sv
// Combinational 9-tap signed MAC plus arithmetic shift, saturation and optional ReLU.
// Define CONV_SEQUENCER_RELU_EN to clamp negative outputs to zero.
module conv_mac9
    import conv_pkg::*;
#(
    parameter int N     = conv_pkg::N,
    parameter int ACC_W = conv_pkg::ACC_W,
    parameter int SHIFT = 0
) (
    input  logic [9*N-1:0]          win_i,
    input  logic [9*N-1:0]          wgt_i,
    output logic signed [ACC_W-1:0] acc_o,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [N-1:0]            d_o
);
    localparam int TAPS = FIL * FIL;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (N - 1)));

    function automatic logic signed [ACC_W-1:0] prod_ext(input logic signed [N-1:0] a,
                                                         input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = a * b;
        return ACC_W'(p);
    endfunction

    function automatic logic signed [N-1:0] sat_n(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[N-1:0];
        if (v < SAT_MIN) return SAT_MIN[N-1:0];
        return v[N-1:0];
    endfunction

`ifdef CONV_SEQUENCER_RELU_EN
    function automatic logic signed [N-1:0] relu(input logic signed [N-1:0] v);
        return v[N-1] ? '0 : v;
    endfunction
`endif

    always_comb begin
        acc_o = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_o = acc_o + prod_ext(win_i[k*N +: N], wgt_i[k*N +: N]);
        end
    end

`ifdef CONV_SEQUENCER_RELU_EN
    assign d_o = relu(sat_n(acc_i >>> SHIFT));
`else
    assign d_o = sat_n(acc_i >>> SHIFT);
`endif
endmodule

// File: rtl/conv_sequencer.sv
// Raster-scans a 3x3 kernel over an IMG x IMG map: ADDR -> READ -> WRITE per output pixel.
// Output post-processing (ReLU) is selected by CONV_SEQUENCER_RELU_EN inside conv_mac9.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int N     = conv_pkg::N,
    parameter int M_AW  = conv_pkg::M_AW,
    parameter int F_AW  = conv_pkg::F_AW,
    parameter int IMG   = conv_pkg::IMG,
    parameter int FIL   = conv_pkg::FIL,
    parameter int SHIFT = 0
) (
    input  logic             clock,
    input  logic             rst_n,
    conv_sequencer_if.master bus
);
    localparam int ODIM     = IMG - FIL + 1;
    localparam int CW       = $clog2(ODIM);
    localparam int ACC_BITS = 2 * N + 4;
    localparam logic [CW-1:0]   LAST     = CW'(ODIM - 1);
    localparam logic [M_AW-1:0] ROW_STEP = M_AW'(IMG);
    localparam logic [M_AW-1:0] OUT_STEP = M_AW'(ODIM);

    state_t                     state_q, state_d;
    logic [CW-1:0]              r_q, r_d, c_q, c_d;
    logic [M_AW-1:0]            src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [M_AW-1:0]            src1_q, src1_d, dest_q, dest_d;
    logic [F_AW-1:0]            src2_q, src2_d;
    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic                       wren_q, wren_d, busy_q, busy_d, done_q, done_d;
    logic signed [ACC_BITS-1:0] mac_acc;
    logic [N-1:0]               mac_d;
    logic                       unused_slot9;

    // Window slot 9 carries nothing useful for a 3x3 kernel.
    assign unused_slot9 = ^bus.I_out[10*N-1:9*N];

    conv_mac9 #(
        .N     (N),
        .ACC_W (ACC_BITS),
        .SHIFT (SHIFT)
    ) u_mac (
        .win_i (bus.I_out[9*N-1:0]),
        .wgt_i (bus.F_out),
        .acc_o (mac_acc),
        .acc_i (acc_q),
        .d_o   (mac_d)
    );

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        dest_d     = dest_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        wren_d     = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = ADDR;
                    src_base_d = bus.src_base;
                    dst_base_d = bus.dst_base;
                    src2_d     = bus.fil_sel;
                    src1_d     = bus.src_base;
                    r_d        = '0;
                    c_d        = '0;
                    busy_d     = 1'b1;
                end
            end
            ADDR: state_d = READ;
            READ: begin
                state_d = WRITE;
                acc_d   = mac_acc;
                wren_d  = 1'b1;
                dest_d  = dst_base_q + M_AW'(r_q) * OUT_STEP + M_AW'(c_q);
            end
            WRITE: begin
                if (r_q == LAST && c_q == LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    // Column is the fast index; the next window address is set up on entry to ADDR.
                    if (c_q == LAST) begin
                        c_d = '0;
                        r_d = r_q + CW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                    state_d = ADDR;
                    src1_d  = src_base_q + M_AW'(r_d) * ROW_STEP + M_AW'(c_d);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dest_q  <= '0;
            acc_q   <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Latched run bases are pure data and need no reset.
    always_ff @(posedge clock) begin
        src_base_q <= src_base_d;
        dst_base_q <= dst_base_d;
    end

    assign bus.src1 = src1_q;
    assign bus.src2 = src2_q;
    assign bus.wren = wren_q;
    assign bus.dest = dest_q;
    assign bus.D    = mac_d;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized scoreboard bench for conv_sequencer against an arithmetic convolution model.
module tb_conv_sequencer;
    localparam int MEM  = 1024;
    localparam int IMGW = 28;
    localparam int DIM  = 26;
    localparam int LAT  = 2029;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    conv_sequencer_if bus ();

    conv_sequencer dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic signed [7:0] img [MEM];
    logic signed [7:0] fil [8][9];
    wr_t exp_q[$];
    int n_total  = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int cur_fil  = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // External memories: window and weights are registered from the addresses at each edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 9; k++) begin
            bus.I_out[k*8 +: 8] <= img[(int'(bus.src1) + (k / 3) * IMGW + (k % 3)) % MEM];
            bus.F_out[k*8 +: 8] <= fil[bus.src2][k];
        end
        bus.I_out[79:72] <= 8'($urandom);
    end

    function automatic int model_px(input int sb, input int r, input int c, input int f);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(img[(sb + (r + i) * IMGW + c + j) % MEM]) * int'(fil[f][i*3+j]);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef CONV_SEQUENCER_RELU_EN
        if (s < 0) s = 0;
`endif
        return s & 255;
    endfunction

    // Monitor: every write is popped from the scoreboard; done latency is measured from accept.
    always @(negedge clock) begin
        wr_t w;
        if (rst_n) begin
            if (bus.wren) begin
                wr_cnt++;
                chk("busy_during_write", int'(bus.busy), 1);
                chk("src2_held", int'(bus.src2), cur_fil);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: actual dest %0d data %0d, required no write",
                             bus.dest, bus.D);
                end else begin
                    w = exp_q.pop_front();
                    chk("dest", int'(bus.dest), w.addr);
                    chk("data", int'(bus.D), w.data);
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_latency", cyc - acc_cyc + 1, LAT);
            end
        end
    end

    task automatic start_run(input int sb, input int f, input int db);
        @(negedge clock);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                exp_q.push_back('{addr: (db + r * DIM + c) % MEM, data: model_px(sb, r, c, f)});
        cur_fil      = f;
        bus.src_base = 10'(sb);
        bus.fil_sel  = 3'(f);
        bus.dst_base = 10'(db);
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        acc_cyc   = cyc;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("src1_first", int'(bus.src1), sb);
    endtask

    task automatic wait_done(input string name);
        int  d0;
        bit  got;
        d0  = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 2200 && !got; i++) begin
            @(negedge clock);
            #1;
            if (done_cnt != d0) got = 1'b1;
        end
        chk({name, "_done_seen"}, int'(got), 1);
        chk({name, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < MEM; i++) img[i] = 8'($urandom_range(hi - lo, 0) + lo);
    endtask

    task automatic fil_rand(input int f, input int lo, input int hi);
        for (int k = 0; k < 9; k++) fil[f][k] = 8'($urandom_range(hi - lo, 0) + lo);
    endtask

    initial begin
        int w0, d0;
        bus.start    = 1'b0;
        bus.src_base = '0;
        bus.fil_sel  = '0;
        bus.dst_base = '0;
        for (int f = 0; f < 8; f++) for (int k = 0; k < 9; k++) fil[f][k] = '0;
        for (int i = 0; i < MEM; i++) img[i] = '0;

        repeat (3) @(negedge clock);
        chk("reset_wren", int'(bus.wren), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_src1", int'(bus.src1), 0);
        chk("reset_dest", int'(bus.dest), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // All ones: every output 9, writes 800..1023 then wrapping to 451.
        for (int i = 0; i < MEM; i++) img[i] = 8'sd1;
        for (int k = 0; k < 9; k++) fil[0][k] = 8'sd1;
        start_run(0, 0, 800);
        wait_done("ones");

        // Positive and negative saturation.
        for (int i = 0; i < MEM; i++) img[i] = 8'sd127;
        for (int k = 0; k < 9; k++) fil[1][k] = 8'sd127;
        for (int k = 0; k < 9; k++) fil[2][k] = -8'sd128;
        start_run(100, 1, 0);
        wait_done("sat_pos");
        start_run(100, 2, 0);
        wait_done("sat_neg");

        // Destination wrap at 1023 -> 0 with small random data to exercise unsaturated sums.
        fill_rand(-8, 7);
        fil_rand(3, -4, 3);
        start_run(900, 3, 1000);
        wait_done("dst_wrap");

        // Ramp image with identity kernel reproduces the centre pixel.
        for (int i = 0; i < MEM; i++) img[i] = 8'(i % 8);
        for (int k = 0; k < 9; k++) fil[4][k] = (k == 4) ? 8'sd1 : 8'sd0;
        start_run(13, 4, 200);
        wait_done("identity");

        // Asynchronous abort around cycle 100 of a run.
        fill_rand(-128, 127);
        fil_rand(5, -128, 127);
        start_run(37, 5, 500);
        repeat (98) @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wren", int'(bus.wren), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_src1", int'(bus.src1), 0);
        chk("abort_src2", int'(bus.src2), 0);
        chk("abort_dest", int'(bus.dest), 0);
        chk("abort_D", int'(bus.D), 0);
        exp_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        repeat (60) @(negedge clock);
        chk("abort_no_writes", wr_cnt - w0, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", int'(bus.busy), 0);

        fil_rand(6, -6, 5);
        fill_rand(-20, 20);
        start_run(250, 6, 7);
        wait_done("after_abort");

        // Start re-pulsed while busy and during FIN must not restart.
        w0 = wr_cnt;
        d0 = done_cnt;
        fil_rand(7, -128, 127);
        start_run(600, 7, 300);
        repeat (48) @(posedge clock);
        #1;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_done("repulse");
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (30) @(negedge clock);
        chk("repulse_writes", wr_cnt - w0, DIM * DIM);
        chk("repulse_done_count", done_cnt - d0, 1);
        chk("repulse_idle", int'(bus.busy), 0);

        fill_rand(-128, 127);
        fil_rand(3, -3, 3);
        start_run($urandom_range(1023, 0), 3, $urandom_range(1023, 0));
        wait_done("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
